// File: rtl/disp_pkg.sv
// Shared display constants: segment patterns, widths, capture FSM states.
// Used by the scan capture monitor and the CPU's display encoder.
package disp_pkg;

  localparam int NIB_W   = 4;
  localparam int SEG_W   = 7;
  localparam int CODE_W  = 8;
  localparam int WHICH_W = 3;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  typedef enum logic {
    IDLE,
    COLLECT
  } cap_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Active-low 7-segment pattern to hex nibble.
// valid is low for any pattern that is not one of the 16 digits.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nib,
  output logic             valid
);

  // Match the pattern against the digit table
  always_comb begin
    nib   = '0;
    valid = 1'b1;
    unique case (1'b1)
      (seg == SEG_0): nib = 4'h0;
      (seg == SEG_1): nib = 4'h1;
      (seg == SEG_2): nib = 4'h2;
      (seg == SEG_3): nib = 4'h3;
      (seg == SEG_4): nib = 4'h4;
      (seg == SEG_5): nib = 4'h5;
      (seg == SEG_6): nib = 4'h6;
      (seg == SEG_7): nib = 4'h7;
      (seg == SEG_8): nib = 4'h8;
      (seg == SEG_9): nib = 4'h9;
      (seg == SEG_A): nib = 4'hA;
      (seg == SEG_B): nib = 4'hB;
      (seg == SEG_C): nib = 4'hC;
      (seg == SEG_D): nib = 4'hD;
      (seg == SEG_E): nib = 4'hE;
      (seg == SEG_F): nib = 4'hF;
      default:        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Scanned 7-segment capture: debounce, decode, reassemble displayed value.
// SEG_CAPTURE_DP_EN adds dp_bits (decimal points, 1 = lit).
module seg_scan_capture
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CNT = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk_on,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [WHICH_W-1:0]          which,
  input  logic [CODE_W-1:0]           code,
  output logic [NIB_W*NUM_DIGITS-1:0] value,
  output logic                        value_valid,
  output logic                        frame_done,
  output logic                        changed,
  output logic                        timeout,
  output logic                        bad_code,
  output logic [NUM_DIGITS-1:0]       digit_mask
`ifdef SEG_CAPTURE_DP_EN
  ,
  output logic [NUM_DIGITS-1:0]       dp_bits
`endif
);

  localparam int VW = NIB_W * NUM_DIGITS;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]    SC    = 4'(STABLE_CNT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [WHICH_W+CODE_W-1:0] pair;
  logic [WHICH_W+CODE_W-1:0] last_q;
  logic [3:0]                cnt_q;
  logic [3:0]                cnt_d;
  logic                      acc;
  logic                      in_rng;
  logic                      take;
  logic                      bad_hit;
  logic                      full;
  logic                      dp_diff;
  logic [NIB_W-1:0]          nib;
  logic                      nib_ok;

  cap_state_t                state_q;
  cap_state_t                state_d;
  logic [TW-1:0]             tcnt_q;
  logic [TW-1:0]             tcnt_d;
  logic [VW-1:0]             shadow_q;
  logic [VW-1:0]             shadow_d;
  logic [VW-1:0]             value_d;
  logic [NUM_DIGITS-1:0]     mask_acc;
  logic [NUM_DIGITS-1:0]     mask_d;
  logic                      vv_d;
  logic                      done_d;
  logic                      chg_d;
  logic                      tmo_d;
  logic                      bad_d;

  seg7_decode u_dec (
    .seg   (code[SEG_W-1:0]),
    .nib   (nib),
    .valid (nib_ok)
  );

  // Stability filter: one accept per stable hold of {which,code}
  always_comb begin
    pair  = {which, code};
    cnt_d = cnt_q;
    acc   = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (pair != last_q) begin
      cnt_d = 4'd1;
      acc   = (SC == 4'd1);
    end else if (cnt_q < SC) begin
      cnt_d = cnt_q + 4'd1;
      acc   = (cnt_d == SC);
    end
  end

  assign in_rng  = (int'(which) < NUM_DIGITS);
  assign take    = acc && in_rng && nib_ok;
  assign bad_hit = acc && in_rng && !nib_ok;

`ifdef SEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] dps_q;
  logic [NUM_DIGITS-1:0] dps_d;
  logic [NUM_DIGITS-1:0] dpb_d;

  // Decimal points follow the digit they were shown with
  always_comb begin
    dps_d = dps_q;
    if (take) begin
      dps_d[which] = ~code[CODE_W-1];
    end
    dpb_d   = full ? dps_d : dp_bits;
    dp_diff = (dps_d != dp_bits);
  end

  // Decimal point state registers
  always_ff @(posedge clk_on) begin
    if (rst) begin
      dps_q   <= '0;
      dp_bits <= '0;
    end else begin
      dps_q   <= dps_d;
      dp_bits <= dpb_d;
    end
  end
`else
  assign dp_diff = 1'b0;
`endif

  // Merge an accepted digit into the shadow frame
  always_comb begin
    mask_acc = digit_mask;
    shadow_d = shadow_q;
    if (take) begin
      mask_acc[which]                = 1'b1;
      shadow_d[NIB_W*which +: NIB_W] = nib;
    end
  end

  assign full = take && (&mask_acc);

  // Frame FSM: completion wins over timeout
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    mask_d  = mask_acc;
    value_d = value;
    vv_d    = value_valid;
    done_d  = 1'b0;
    chg_d   = 1'b0;
    tmo_d   = 1'b0;
    bad_d   = bad_code | bad_hit;
    if (full) begin
      value_d = shadow_d;
      done_d  = 1'b1;
      chg_d   = (shadow_d != value) || dp_diff || !value_valid;
      vv_d    = 1'b1;
      mask_d  = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            state_d = COLLECT;
            tcnt_d  = '0;
          end
        end
        COLLECT: begin
          if (tcnt_q == TLAST) begin
            mask_d  = '0;
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  // Filter state registers
  always_ff @(posedge clk_on) begin
    if (rst) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enable) begin
        last_q <= pair;
      end
      cnt_q <= cnt_d;
    end
  end

  // Frame state and output registers
  always_ff @(posedge clk_on) begin
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      shadow_q    <= '0;
      digit_mask  <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_done  <= 1'b0;
      changed     <= 1'b0;
      timeout     <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      shadow_q    <= shadow_d;
      digit_mask  <= mask_d;
      value       <= value_d;
      value_valid <= vv_d;
      frame_done  <= done_d;
      changed     <= chg_d;
      timeout     <= tmo_d;
      bad_code    <= bad_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (default build).
// Frame-level model compared every cycle plus literal spot checks.
module tb_seg_scan_capture;

  localparam int ND = 8;
  localparam int SC = 2;
  localparam int TO = 64;

  logic        clk_on = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  which;
  logic [7:0]  code;
  logic [31:0] value;
  logic        value_valid;
  logic        frame_done;
  logic        changed;
  logic        timeout;
  logic        bad_code;
  logic [7:0]  digit_mask;
`ifdef SEG_CAPTURE_DP_EN
  logic [7:0]  dp_bits;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_on = ~clk_on;

  seg_scan_capture #(
    .NUM_DIGITS (ND),
    .STABLE_CNT (SC),
    .TIMEOUT    (TO)
  ) dut (
    .clk_on      (clk_on),
    .rst         (rst),
    .enable      (enable),
    .which       (which),
    .code        (code),
    .value       (value),
    .value_valid (value_valid),
    .frame_done  (frame_done),
    .changed     (changed),
    .timeout     (timeout),
    .bad_code    (bad_code),
`ifdef SEG_CAPTURE_DP_EN
    .dp_bits     (dp_bits),
`endif
    .digit_mask  (digit_mask)
  );

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [7:0] c);
    for (int i = 0; i < 16; i++)
      if (seg_tab[i][6:0] == c[6:0]) return i;
    return -1;
  endfunction

  // Model state: frame as a set of captured digits
  bit          armed = 1'b0;
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_nib [8];
  bit          m_have [8];
  bit          m_active;
  int          m_cyc;
  int          m_t0;
  logic [31:0] e_value;
  bit          e_vv, e_done, e_chg, e_tmo, e_bad;

  function automatic bit all_have();
    for (int i = 0; i < ND; i++)
      if (!m_have[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] have_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < ND; i++) m[i] = m_have[i];
    return m;
  endfunction

  // Model update on every sampling edge
  always @(posedge clk_on) begin
    logic [31:0] nv;
    int          d;
    bit          took;
    if (rst) begin
      armed    = 1'b1;
      m_prev   = '0;
      m_run    = 0;
      m_active = 1'b0;
      m_cyc    = 0;
      m_t0     = 0;
      for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
      e_value = '0;
      e_vv = 0; e_done = 0; e_chg = 0; e_tmo = 0; e_bad = 0;
    end else begin
      m_cyc++;
      e_done = 0; e_chg = 0; e_tmo = 0; took = 0;
      if (!enable) m_run = 0;
      else if ({which, code} != m_prev) begin
        m_prev = {which, code};
        m_run  = 1;
      end else m_run++;
      if (enable && m_run == SC && int'(which) < ND) begin
        d = decode(code);
        if (d < 0) e_bad = 1'b1;
        else begin
          m_nib[which]  = 4'(d);
          m_have[which] = 1'b1;
          took = 1'b1;
        end
      end
      if (took && all_have()) begin
        for (int k = 0; k < ND; k++) nv[4*k +: 4] = m_nib[k];
        e_chg   = (nv != e_value) || !e_vv;
        e_value = nv;
        e_vv    = 1'b1;
        e_done  = 1'b1;
        for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
        m_active = 1'b0;
      end else if (m_active) begin
        if (m_cyc - m_t0 == TO) begin
          e_tmo = 1'b1;
          for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
          m_active = 1'b0;
        end
      end else if (took) begin
        m_active = 1'b1;
        m_t0     = m_cyc;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_on) begin
    if (armed) begin
      check("value",       value,       e_value);
      check("value_valid", 32'(value_valid), 32'(e_vv));
      check("frame_done",  32'(frame_done),  32'(e_done));
      check("changed",     32'(changed),     32'(e_chg));
      check("timeout",     32'(timeout),     32'(e_tmo));
      check("bad_code",    32'(bad_code),    32'(e_bad));
      check("digit_mask",  32'(digit_mask),  32'(have_mask()));
    end
  end

  task automatic hold(input logic [2:0] w, input logic [7:0] c,
                      input logic en, input int n);
    which  = w;
    code   = c;
    enable = en;
    repeat (n) @(posedge clk_on);
    #1;
  endtask

  task automatic scan(input logic [31:0] v, input int ndig, input int n);
    for (int k = 0; k < ndig; k++)
      hold(3'(k), seg_tab[v[4*k +: 4]], 1'b1, n);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0; which = '0; code = 8'hFF;
    repeat (2) @(posedge clk_on);
    #1;
    check("rst_value", value, 32'h0);
    check("rst_vv", 32'(value_valid), 32'h0);
    check("rst_mask", 32'(digit_mask), 32'h0);
    rst = 1'b0;

    scan(32'h12345678, 8, 2);
    check("scan1_done", 32'(frame_done), 32'h1);
    check("scan1_chg", 32'(changed), 32'h1);
    check("scan1_value", value, 32'h12345678);
    check("scan1_vv", 32'(value_valid), 32'h1);

    scan(32'h12345678, 8, 2);
    check("scan2_done", 32'(frame_done), 32'h1);
    check("scan2_chg", 32'(changed), 32'h0);
    check("scan2_value", value, 32'h12345678);

    scan(32'h9ABCDEF0, 8, 1);
    check("short_mask", 32'(digit_mask), 32'h0);
    check("short_done", 32'(frame_done), 32'h0);

    for (int i = 0; i < 6; i++) hold(3'd2, seg_tab[5], (i % 2) == 0, 1);
    check("toggle_mask", 32'(digit_mask), 32'h0);

    hold(3'd3, 8'hFF, 1'b1, 2);
    check("bad_set", 32'(bad_code), 32'h1);
    check("bad_mask", 32'(digit_mask), 32'h0);
    hold(3'd3, 8'hFF, 1'b0, 2);
    check("bad_sticky", 32'(bad_code), 32'h1);

    scan(32'h12345678, 7, 2);
    check("partial_mask", 32'(digit_mask), 32'h7F);
    k = 14;
    while (k < 120 && !timeout) begin
      @(posedge clk_on);
      #1;
      k++;
    end
    check("timeout_at", k, 66);
    check("tmo_mask", 32'(digit_mask), 32'h0);
    check("tmo_value", value, 32'h12345678);

    scan(32'hCAFE0000, 4, 2);
    check("pre_rst_mask", 32'(digit_mask), 32'h0F);
    rst = 1'b1;
    @(posedge clk_on);
    #1;
    check("mid_rst_value", value, 32'h0);
    check("mid_rst_vv", 32'(value_valid), 32'h0);
    check("mid_rst_mask", 32'(digit_mask), 32'h0);
    check("mid_rst_bad", 32'(bad_code), 32'h0);
    rst = 1'b0;

    scan(32'hDEADBEEF, 8, 2);
    check("dead_value", value, 32'hDEADBEEF);
    check("dead_done", 32'(frame_done), 32'h1);
    check("dead_chg", 32'(changed), 32'h1);

    hold(3'd0, 8'hFF, 1'b0, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
